// File: rtl/mem_dump_if.sv
// Bundles the dump request, memory read port and output word stream of mem_dump_unit.
// The checksum signal exists only when DUMP_CHECKSUM_EN is defined.
interface mem_dump_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   count;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] dout;
    logic [ADDR_W-1:0] dout_addr;
    logic              dout_valid;
    logic              dout_ready;
    logic              busy;
    logic              done;
`ifdef DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;
`endif

    modport slave (
        input  start, base_addr, count, mem_rdata, dout_ready,
        output mem_re, mem_addr, dout, dout_addr, dout_valid, busy, done
`ifdef DUMP_CHECKSUM_EN
        , output checksum
`endif
    );

    modport master (
        output start, base_addr, count, mem_rdata, dout_ready,
        input  mem_re, mem_addr, dout, dout_addr, dout_valid, busy, done
`ifdef DUMP_CHECKSUM_EN
        , input checksum
`endif
    );
endinterface

// File: rtl/mem_dump_unit.sv
// Reads count words starting at base_addr from a 1-cycle-latency memory and streams them out.
// Optional running checksum of transferred words when DUMP_CHECKSUM_EN is defined.
module mem_dump_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input logic      clk,
    input logic      rst,
    mem_dump_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RD, WT, OUT, FIN} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_p0;
    logic [ADDR_W:0]   rem_p0;
    logic [DATA_W-1:0] dout_p1;
    logic [ADDR_W-1:0] dout_addr_p1;
    logic              xfer;
    logic              accept;

    function automatic logic [DATA_W-1:0] wrap_add(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        return a + b;
    endfunction

    assign accept = (state == IDLE) && bus.start;
    assign xfer   = (state == OUT) && bus.dout_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start) state_nxt = (bus.count == '0) ? FIN : RD;
            RD:   state_nxt = WT;
            WT:   state_nxt = OUT;
            OUT:  if (bus.dout_ready)
                      state_nxt = (rem_p0 == (ADDR_W+1)'(1)) ? FIN : RD;
            FIN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Address/remaining-word bookkeeping; address wraps naturally at 2^ADDR_W
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_p0 <= '0;
            rem_p0  <= '0;
        end else if (accept && bus.count != '0) begin
            addr_p0 <= bus.base_addr;
            rem_p0  <= bus.count;
        end else if (xfer) begin
            addr_p0 <= addr_p0 + ADDR_W'(1);
            rem_p0  <= rem_p0 - (ADDR_W+1)'(1);
        end
    end

    // Memory data captured at end of WT; held until the next WT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_p1      <= '0;
            dout_addr_p1 <= '0;
        end else if (state == WT) begin
            dout_p1      <= bus.mem_rdata;
            dout_addr_p1 <= addr_p0;
        end
    end

    assign bus.mem_re     = (state == RD);
    assign bus.mem_addr   = addr_p0;
    assign bus.dout       = dout_p1;
    assign bus.dout_addr  = dout_addr_p1;
    assign bus.dout_valid = (state == OUT);
    assign bus.busy       = (state != IDLE);
    assign bus.done       = (state == FIN);

`ifdef DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         checksum_p1 <= '0;
        else if (accept) checksum_p1 <= '0;
        else if (xfer)   checksum_p1 <= wrap_add(checksum_p1, dout_p1);
    end

    assign bus.checksum = checksum_p1;
`endif
endmodule

// File: doc/mem_dump_unit.md
MEM_DUMP_UNIT -- requirements
Module: mem_dump_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, word width of the dumped memory.
REQ-002 SHALL have parameter ADDR_W, default 5, address width of the dumped memory (32-entry register bank).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port start, input, 1, request to begin a dump; sampled only in IDLE.
REQ-006 SHALL have port base_addr, input, ADDR_W, first address to dump; sampled with start.
REQ-007 SHALL have port count, input, ADDR_W+1, number of words to dump (0..2^ADDR_W); sampled with start.
REQ-008 SHALL have port mem_re, output, 1, memory read enable.
REQ-009 SHALL have port mem_addr, output, ADDR_W, memory read address.
REQ-010 SHALL have port mem_rdata, input, DATA_W, read data, valid one cycle after mem_re.
REQ-011 SHALL have port dout, output, DATA_W, dumped word.
REQ-012 SHALL have port dout_addr, output, ADDR_W, address of the word on dout.
REQ-013 SHALL have port dout_valid, output, 1, dout/dout_addr hold a word.
REQ-014 SHALL have port dout_ready, input, 1, consumer accepts the word.
REQ-015 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-016 SHALL have port done, output, 1, one-cycle pulse when a dump completes.

Function
REQ-017 SHALL implement states IDLE, RD, WT, OUT, FIN.
REQ-018 In IDLE with start=1 and count!=0, the block SHALL latch base_addr and count and go to RD.
REQ-019 In IDLE with start=1 and count=0, the block SHALL go to FIN without asserting mem_re.
REQ-020 In RD, the block SHALL assert mem_re=1 with mem_addr at the current address, then go to WT; mem_re SHALL be 0 in all other states.
REQ-021 At the end of WT, the block SHALL register mem_rdata into dout and the current address into dout_addr, then go to OUT.
REQ-022 In OUT, the block SHALL drive dout_valid=1 and hold dout/dout_addr stable while dout_ready=0.
REQ-023 A transfer SHALL occur on a cycle with dout_valid=1 and dout_ready=1. After a transfer, the block SHALL go to RD if words remain, else to FIN.
REQ-024 Latency: with start high in cycle 0, dout_valid SHALL first be high in cycle 3. With dout_ready held high, there SHALL be one word every 3 cycles.
REQ-025 The address SHALL increment by 1 per transfer, modulo 2^ADDR_W (31 wraps to 0).
REQ-026 FIN SHALL last one cycle with done=1, then go to IDLE.
REQ-027 start asserted while busy=1 SHALL be ignored.
REQ-028 When dout_valid=0, dout and dout_addr SHALL retain their last transferred values.

Reset
REQ-029 rst=1 SHALL immediately force state IDLE and set mem_re, mem_addr, dout, dout_addr, dout_valid, busy, done and checksum to 0.
REQ-030 Reset mid-dump SHALL abandon the dump, with no done pulse and no further transfers.

Configuration
REQ-031 With DUMP_CHECKSUM_EN defined, the block SHALL provide output port checksum (DATA_W). checksum SHALL be cleared on an accepted start and SHALL add each transferred word modulo 2^DATA_W. checksum SHALL be stable from the done cycle until the next start.
REQ-032 Without DUMP_CHECKSUM_EN defined, the checksum port and its adder SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-033 Memory[i]=i*3, base_addr=0, count=4, dout_ready=1 -> dout sequence 0,3,6,9 with dout_addr 0..3; first dout_valid in cycle 3; done pulse one cycle after the 4th transfer.
REQ-034 base_addr=30, count=4 -> dout_addr sequence 30,31,0,1.
REQ-035 dout_ready=0 for 5 cycles during the first OUT -> dout_valid stays 1; dout and dout_addr stay constant; mem_re stays 0 until the transfer occurs.
REQ-036 start with count=0 -> no mem_re, no dout_valid, done=1 in cycle 1, busy=1 in cycle 1 only.
REQ-037 rst pulsed in the 2nd WT of a count=8 dump -> all outputs 0 that cycle; no done pulse; a new start then behaves as in REQ-033.
REQ-038 With DUMP_CHECKSUM_EN defined, words 0xFFFFFFFF and 0x00000002 dumped -> checksum=0x00000001 at done.
